// File: rtl/audio_pkg.sv
// audio_pkg: shared Q-format constants and the round/saturate helper for gain stages
package audio_pkg;
  localparam int W = 32;
  localparam int W_FRAC = 16;
  localparam int OUT_W = 16;
  localparam int DEPTH = 4;

  // Round-half-up a Q(2*W_FRAC) product to integer and clamp to signed OUT_W; MSB flags a clamp
  function automatic logic [OUT_W:0] sat_round(input logic signed [2*W-1:0] prod);
    logic signed [2*W-1:0] r;
    logic signed [2*W-1:0] hi;
    logic signed [2*W-1:0] lo;
    hi = (2*W)'(2**(OUT_W-1) - 1);
    lo = -(2*W)'(2**(OUT_W-1));
    r = (prod + ((2*W)'(1) <<< (2*W_FRAC-1))) >>> (2*W_FRAC);
    return (r > hi) ? {1'b1, hi[OUT_W-1:0]} :
           (r < lo) ? {1'b1, lo[OUT_W-1:0]} : {1'b0, r[OUT_W-1:0]};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with registered storage, occupancy count and simultaneous push/pop
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  end

  // storage needs no reset: the head is only observed when the count is nonzero
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // head and empty come straight from registered state
  always_comb begin
    head = mem[rd_ptr];
    empty = (count == '0);
  end
endmodule

// File: rtl/decim_gain_sat.sv
// decim_gain_sat: decimate Q16.16 samples, apply gain, round/saturate to PCM and buffer in a FIFO
module decim_gain_sat #(
  parameter int W = audio_pkg::W,
  parameter int W_FRAC = audio_pkg::W_FRAC,
  parameter int OUT_W = audio_pkg::OUT_W,
  parameter int DEPTH = audio_pkg::DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic signed [W-1:0]     x_data,
  input  logic [3:0]              decim,
  input  logic signed [W-1:0]     gain,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic [OUT_W-1:0]        y_data,
  output logic                    clip,
  input  logic                    clip_clr
);
  import audio_pkg::*;
  localparam int CW = $clog2(DEPTH+1);

  // sat_round is fixed to the package Q-format, so any override must agree with it
  if (W != audio_pkg::W || W_FRAC != audio_pkg::W_FRAC || OUT_W != audio_pkg::OUT_W) begin : g_fmt_check
    $error("decim_gain_sat: Q-format parameters must match audio_pkg");
  end

  logic [3:0] phase, m_cur, m_eff;
  logic s1_valid, s2_valid, accept, keep, empty;
  logic signed [2*W-1:0] s1_prod;
  logic [OUT_W-1:0] s2_data, head;
  logic [OUT_W:0] sr;
  logic [CW-1:0] count;
  logic [CW:0] used;

  // credits cover every sample already headed for the FIFO, so a kept sample always finds room
  always_comb begin
    used = {1'b0, count} + {{CW{1'b0}}, s1_valid} + {{CW{1'b0}}, s2_valid};
    x_ready = used < (CW+1)'(DEPTH);
    accept = x_valid & x_ready;
    keep = accept & (phase == 4'd0);
    m_eff = keep ? ((decim == 4'd0) ? 4'd1 : decim) : m_cur;
    sr = sat_round(s1_prod);
    y_valid = ~empty;
    y_data = y_valid ? head : '0;
  end

  // decimation phase; a kept sample latches the new factor, which already governs this wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 4'd0;
      m_cur <= 4'd1;
    end else if (accept) begin
      phase <= (phase == m_eff - 4'd1) ? 4'd0 : phase + 4'd1;
      if (keep) m_cur <= m_eff;
    end
  end

  // S1 full-precision product, S2 rounded/saturated PCM and sticky clip (set beats clear)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_prod <= '0;
      s2_valid <= 1'b0;
      s2_data <= '0;
      clip <= 1'b0;
    end else begin
      s1_valid <= keep;
      if (keep) s1_prod <= (2*W)'(x_data) * (2*W)'(gain);
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= sr[OUT_W-1:0];
      clip <= (s1_valid & sr[OUT_W]) | (clip & ~clip_clr);
    end
  end

  sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(s2_valid),
    .din(s2_data),
    .pop(y_valid & y_ready),
    .head(head),
    .count(count),
    .empty(empty)
  );
endmodule
